// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS front-end: branch types, next-PC source
// selects and the default reset/exception vectors.
package mips_pkg;

    localparam int unsigned BR_TYPE_W = 3;
    localparam int unsigned PCSRC_W   = 2;

    localparam logic [BR_TYPE_W-1:0] BR_BEQ  = 3'd0;
    localparam logic [BR_TYPE_W-1:0] BR_BNE  = 3'd1;
    localparam logic [BR_TYPE_W-1:0] BR_BLEZ = 3'd2;
    localparam logic [BR_TYPE_W-1:0] BR_BGTZ = 3'd3;
    localparam logic [BR_TYPE_W-1:0] BR_BLTZ = 3'd4;
    localparam logic [BR_TYPE_W-1:0] BR_BGEZ = 3'd5;

    localparam logic [PCSRC_W-1:0] PCSRC_ALU    = 2'd0;
    localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [PCSRC_W-1:0] PCSRC_JR     = 2'd3;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h8000_0180;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch-condition evaluator: decides whether a conditional
// branch of the given type is taken from the ALU Zero/Sign flags.
module branch_cond_eval
    import mips_pkg::*;
(
    input  logic [BR_TYPE_W-1:0] br_type,
    input  logic                 zero,
    input  logic                 sign,
    output logic                 cond_ok_c
);

    // Types 6-7 are reserved and never taken.
    always_comb begin
        cond_ok_c = 1'b0;
        case (br_type)
            BR_BEQ:  cond_ok_c = zero;
            BR_BNE:  cond_ok_c = ~zero;
            BR_BLEZ: cond_ok_c = sign | zero;
            BR_BGTZ: cond_ok_c = ~sign & ~zero;
            BR_BLTZ: cond_ok_c = sign;
            BR_BGEZ: cond_ok_c = ~sign;
            default: cond_ok_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_update_unit.sv
// PC register with branch evaluation, next-PC source select and misaligned
// target redirect. PC_PERF_CNT_EN adds saturating branch/redirect counters.
module pc_update_unit
    import mips_pkg::*;
#(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(DEFAULT_RESET_PC),
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEFAULT_EXC_VECTOR)
`ifdef PC_PERF_CNT_EN
    ,
    parameter int unsigned      CNT_W      = 32
`endif
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 PCWrite,
    input  logic                 PCWriteCond,
    input  logic [BR_TYPE_W-1:0] BranchType,
    input  logic                 jr_control,
    input  logic [PCSRC_W-1:0]   PCSource,
    input  logic                 Zero,
    input  logic                 Sign,
    input  logic                 stall,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic [WIDTH-1:0]     alu_out,
    input  logic [25:0]          jump_index,
    input  logic [WIDTH-1:0]     jr_target,
    output logic [WIDTH-1:0]     pc,
    output logic                 PCWriteetc,
    output logic                 branch_taken,
    output logic                 pc_exc
`ifdef PC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     perf_taken,
    output logic [CNT_W-1:0]     perf_not_taken,
    output logic [CNT_W-1:0]     perf_redirect
`endif
);

    logic             cond_ok;
    logic             write_en;
    logic             misaligned;
    logic             cond_only;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] next_pc;

    branch_cond_eval u_cond (
        .br_type   (BranchType),
        .zero      (Zero),
        .sign      (Sign),
        .cond_ok_c (cond_ok)
    );

    // Pseudo-direct jump: keep the PC's top nibble when the PC is wide enough.
    generate
        if (WIDTH > 28) begin : g_jump_wide
            assign jump_target = {pc[WIDTH-1:28], jump_index, 2'b00};
        end else begin : g_jump_narrow
            assign jump_target = WIDTH'({jump_index, 2'b00});
        end
    endgenerate

    // jr_control outranks PCSource; PCWrite and PCWriteCond share the PCSource mux.
    always_comb begin
        next_pc = alu_result;
        if (jr_control) begin
            next_pc = jr_target;
        end else begin
            case (PCSource)
                PCSRC_ALU:    next_pc = alu_result;
                PCSRC_ALUOUT: next_pc = alu_out;
                PCSRC_JUMP:   next_pc = jump_target;
                PCSRC_JR:     next_pc = jr_target;
                default:      next_pc = alu_result;
            endcase
        end
    end

    always_comb begin
        write_en   = ~stall & (PCWrite | jr_control | (PCWriteCond & cond_ok));
        misaligned = next_pc[1:0] != 2'b00;
        cond_only  = ~stall & PCWriteCond & cond_ok & ~PCWrite & ~jr_control;
    end

    assign PCWriteetc = write_en;

    // Pulses default low each edge; a write either lands or redirects.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc           <= RESET_PC;
            branch_taken <= 1'b0;
            pc_exc       <= 1'b0;
        end else begin
            branch_taken <= 1'b0;
            pc_exc       <= 1'b0;
            if (write_en) begin
                if (misaligned) begin
                    pc     <= EXC_VECTOR;
                    pc_exc <= 1'b1;
                end else begin
                    pc           <= next_pc;
                    branch_taken <= cond_only;
                end
            end
        end
    end

`ifdef PC_PERF_CNT_EN
    logic inc_taken;
    logic inc_not_taken;
    logic inc_redirect;

    always_comb begin
        inc_taken     = cond_only & ~misaligned;
        inc_not_taken = ~stall & PCWriteCond & ~cond_ok;
        inc_redirect  = write_en & (jr_control | misaligned);
    end

    // Saturating event counters; stall suppresses every increment above.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_taken     <= '0;
            perf_not_taken <= '0;
            perf_redirect  <= '0;
        end else begin
            if (inc_taken && (perf_taken != {CNT_W{1'b1}})) begin
                perf_taken <= perf_taken + CNT_W'(1);
            end
            if (inc_not_taken && (perf_not_taken != {CNT_W{1'b1}})) begin
                perf_not_taken <= perf_not_taken + CNT_W'(1);
            end
            if (inc_redirect && (perf_redirect != {CNT_W{1'b1}})) begin
                perf_redirect <= perf_redirect + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_update_unit.sv
// Self-checking bench for pc_update_unit: behavioural PC model compared every
// cycle, plus hand-computed literal checks on key scenarios.
module tb_pc_update_unit;

    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        PCWrite = 1'b0;
    logic        PCWriteCond = 1'b0;
    logic [2:0]  BranchType = 3'd0;
    logic        jr_control = 1'b0;
    logic [1:0]  PCSource = 2'd0;
    logic        Zero = 1'b0;
    logic        Sign = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] alu_result = 32'h0;
    logic [31:0] alu_out = 32'h0;
    logic [25:0] jump_index = 26'h0;
    logic [31:0] jr_target = 32'h0;
    logic [31:0] pc;
    logic        PCWriteetc;
    logic        branch_taken;
    logic        pc_exc;
`ifdef PC_PERF_CNT_EN
    logic [31:0] perf_taken;
    logic [31:0] perf_not_taken;
    logic [31:0] perf_redirect;
`endif

    pc_update_unit dut (
        .clk          (clk),
        .reset        (reset),
        .PCWrite      (PCWrite),
        .PCWriteCond  (PCWriteCond),
        .BranchType   (BranchType),
        .jr_control   (jr_control),
        .PCSource     (PCSource),
        .Zero         (Zero),
        .Sign         (Sign),
        .stall        (stall),
        .alu_result   (alu_result),
        .alu_out      (alu_out),
        .jump_index   (jump_index),
        .jr_target    (jr_target),
        .pc           (pc),
        .PCWriteetc   (PCWriteetc),
        .branch_taken (branch_taken),
        .pc_exc       (pc_exc)
`ifdef PC_PERF_CNT_EN
        ,
        .perf_taken     (perf_taken),
        .perf_not_taken (perf_not_taken),
        .perf_redirect  (perf_redirect)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Condition as a signed comparison of rs with zero, derived from the flags.
    function automatic logic cond_model(input logic [2:0] t, input logic z, input logic s);
        int v;
        v = z ? 0 : (s ? -1 : 1);
        case (t)
            3'd0:    return v == 0;
            3'd1:    return v != 0;
            3'd2:    return v <= 0;
            3'd3:    return v > 0;
            3'd4:    return v < 0;
            3'd5:    return v >= 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic we_model();
        return !stall && (PCWrite || jr_control ||
                          (PCWriteCond && cond_model(BranchType, Zero, Sign)));
    endfunction

    function automatic logic [31:0] target_model(input logic [31:0] cur_pc);
        if (jr_control) return jr_target;
        case (PCSource)
            2'd0:    return alu_result;
            2'd1:    return alu_out;
            2'd2:    return (cur_pc & 32'hF000_0000) | (32'(jump_index) * 32'd4);
            default: return jr_target;
        endcase
    endfunction

    logic [31:0] m_pc = RST_PC;
    logic        m_bt = 1'b0;
    logic        m_exc = 1'b0;
    logic [31:0] m_taken = 32'h0;
    logic [31:0] m_not_taken = 32'h0;
    logic [31:0] m_redirect = 32'h0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc        <= RST_PC;
            m_bt        <= 1'b0;
            m_exc       <= 1'b0;
            m_taken     <= 32'h0;
            m_not_taken <= 32'h0;
            m_redirect  <= 32'h0;
        end else begin
            m_bt  <= 1'b0;
            m_exc <= 1'b0;
            if (!stall && PCWriteCond && !cond_model(BranchType, Zero, Sign))
                m_not_taken <= m_not_taken + 32'd1;
            if (we_model()) begin
                if ((target_model(m_pc) % 32'd4) != 32'd0) begin
                    m_pc       <= EXC_VEC;
                    m_exc      <= 1'b1;
                    m_redirect <= m_redirect + 32'd1;
                end else begin
                    m_pc <= target_model(m_pc);
                    if (jr_control)
                        m_redirect <= m_redirect + 32'd1;
                    if (PCWriteCond && !PCWrite && !jr_control) begin
                        m_bt    <= 1'b1;
                        m_taken <= m_taken + 32'd1;
                    end
                end
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        check("pc", pc, m_pc);
        check("branch_taken", 32'(branch_taken), 32'(m_bt));
        check("pc_exc", 32'(pc_exc), 32'(m_exc));
        check("PCWriteetc", 32'(PCWriteetc), 32'(we_model()));
`ifdef PC_PERF_CNT_EN
        check("perf_taken", perf_taken, m_taken);
        check("perf_not_taken", perf_not_taken, m_not_taken);
        check("perf_redirect", perf_redirect, m_redirect);
`endif
    end

    task automatic idle();
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        jr_control  = 1'b0;
        stall       = 1'b0;
    endtask

    task automatic step(input logic pcw, input logic pcwc, input logic [2:0] bt,
                        input logic jr, input logic [1:0] src, input logic z,
                        input logic s, input logic st, input logic [31:0] ar,
                        input logic [31:0] ao, input logic [25:0] ji,
                        input logic [31:0] jt);
        PCWrite     = pcw;
        PCWriteCond = pcwc;
        BranchType  = bt;
        jr_control  = jr;
        PCSource    = src;
        Zero        = z;
        Sign        = s;
        stall       = st;
        alu_result  = ar;
        alu_out     = ao;
        jump_index  = ji;
        jr_target   = jt;
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("lit_reset_pc", pc, 32'h0000_0000);

        step(1, 0, 3'd0, 0, 2'd0, 0, 0, 0, 32'h40, 32'h0, 26'h0, 32'h0);
        @(negedge clk);
        check("lit_pc_40", pc, 32'h0000_0040);

        // Async reset in the middle of a branch cycle.
        PCWriteCond = 1'b1; BranchType = 3'd1; Zero = 1'b0; PCSource = 2'd1; alu_out = 32'h500;
        #2 reset = 1'b1;
        #1;
        check("lit_midreset_pc", pc, 32'h0000_0000);
        check("lit_midreset_bt", 32'(branch_taken), 32'd0);
        check("lit_midreset_exc", 32'(pc_exc), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        idle();

        step(1, 0, 3'd0, 0, 2'd0, 0, 0, 0, 32'h04, 32'h0, 26'h0, 32'h0);
        @(negedge clk);
        check("lit_pc_04", pc, 32'h0000_0004);
        check("lit_pc_04_bt", 32'(branch_taken), 32'd0);

        step(0, 1, 3'd1, 0, 2'd1, 0, 0, 0, 32'h0, 32'h100, 26'h0, 32'h0);
        @(negedge clk);
        check("lit_bne_pc", pc, 32'h0000_0100);
        check("lit_bne_bt", 32'(branch_taken), 32'd1);
        @(negedge clk);
        check("lit_bne_bt_drop", 32'(branch_taken), 32'd0);
        step(0, 1, 3'd1, 0, 2'd1, 1, 0, 0, 32'h0, 32'h200, 26'h0, 32'h0);
        @(negedge clk);
        check("lit_bne_hold", pc, 32'h0000_0100);

        // All branch types against (Zero,Sign) in {00,01,10}.
        for (int t = 0; t < 8; t++) begin
            for (int c = 0; c < 3; c++) begin
                step(0, 1, 3'(t), 0, 2'd1, c == 2, c == 1, 0, 32'h0,
                     32'h1000 + 32'((t * 3 + c) * 16), 26'h0, 32'h0);
            end
        end
        step(0, 1, 3'd2, 0, 2'd1, 1, 0, 0, 32'h0, 32'h2000, 26'h0, 32'h0);
        @(negedge clk);
        check("lit_blez_zero_pc", pc, 32'h0000_2000);
        check("lit_blez_zero_bt", 32'(branch_taken), 32'd1);

        // PCWriteetc is combinational and gated by stall.
        PCWriteCond = 1'b1; BranchType = 3'd3; Zero = 1'b0; Sign = 1'b0;
        #1 check("lit_we_bgtz", 32'(PCWriteetc), 32'd1);
        stall = 1'b1;
        #1 check("lit_we_stall", 32'(PCWriteetc), 32'd0);
        idle();

        step(0, 0, 3'd0, 1, 2'd0, 0, 0, 0, 32'h0, 32'h0, 26'h0, 32'h103);
        @(negedge clk);
        check("lit_jr_mis_pc", pc, 32'h8000_0180);
        check("lit_jr_mis_exc", 32'(pc_exc), 32'd1);
        step(0, 0, 3'd0, 1, 2'd0, 0, 0, 1, 32'h0, 32'h0, 26'h0, 32'h103);
        @(negedge clk);
        check("lit_jr_stall_pc", pc, 32'h8000_0180);
        check("lit_jr_stall_exc", 32'(pc_exc), 32'd0);

        // Priority: PCWrite wins over PCWriteCond; jr wins over PCWrite.
        step(1, 1, 3'd0, 0, 2'd0, 1, 0, 0, 32'h300, 32'h700, 26'h0, 32'h0);
        @(negedge clk);
        check("lit_prio_pc", pc, 32'h0000_0300);
        check("lit_prio_bt", 32'(branch_taken), 32'd0);
        step(1, 0, 3'd0, 1, 2'd0, 0, 0, 0, 32'h400, 32'h0, 26'h0, 32'h880);
        @(negedge clk);
        check("lit_jr_prio_pc", pc, 32'h0000_0880);

        step(0, 1, 3'd0, 0, 2'd1, 1, 0, 0, 32'h0, 32'h102, 26'h0, 32'h0);
        @(negedge clk);
        check("lit_br_mis_pc", pc, 32'h8000_0180);
        check("lit_br_mis_bt", 32'(branch_taken), 32'd0);

        step(1, 0, 3'd0, 0, 2'd0, 0, 0, 0, 32'hF000_0010, 32'h0, 26'h0, 32'h0);
        step(1, 0, 3'd0, 0, 2'd2, 0, 0, 0, 32'h0, 32'h0, 26'h000_0040, 32'h0);
        @(negedge clk);
        check("lit_jump_pc", pc, 32'hF000_0100);

        step(1, 0, 3'd0, 0, 2'd0, 0, 0, 0, 32'hFFFF_FFFC, 32'h0, 26'h0, 32'h0);
        step(1, 0, 3'd0, 0, 2'd0, 0, 0, 0, 32'h0000_0000, 32'h0, 26'h0, 32'h0);
        @(negedge clk);
        check("lit_wrap_pc", pc, 32'h0000_0000);
        check("lit_wrap_exc", 32'(pc_exc), 32'd0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_update_unit.md
Name: pc_update_unit

Overview:
Parametrised successor to the PC write-enable gating in the multi-cycle MIPS datapath. Owns the PC register and evaluates all six conditional-branch types, not just beq. Selects among four next-PC sources and redirects misaligned targets to an exception vector. Sits between the control FSM (write/cond/source strobes) and the ALU (zero/sign, results).

Parameters:
WIDTH, 32, PC and datapath width in bits (>= 8, multiple of 4)
RESET_PC, 32'h0000_0000, PC value loaded on reset
EXC_VECTOR, 32'h8000_0180, PC loaded on misaligned target
CNT_W, 32, width of performance counters (optional feature only)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
PCWrite  in  1  unconditional PC update strobe
PCWriteCond  in  1  conditional PC update strobe (branch cycle)
BranchType  in  3  0 BEQ, 1 BNE, 2 BLEZ, 3 BGTZ, 4 BLTZ, 5 BGEZ, 6-7 never taken
jr_control  in  1  jump-register update strobe
PCSource  in  2  0 alu_result, 1 alu_out, 2 jump target, 3 jr_target
Zero  in  1  ALU zero flag
Sign  in  1  ALU result MSB (operand rs, compared with 0)
stall  in  1  suppresses every PC update this cycle
alu_result  in  WIDTH  PC+4 / combinational ALU output
alu_out  in  WIDTH  registered branch target
jump_index  in  26  instr[25:0]
jr_target  in  WIDTH  register-file read data (rs)
pc  out  WIDTH  current PC
PCWriteetc  out  1  combinational effective write enable
branch_taken  out  1  registered, one-cycle pulse after a taken conditional update
pc_exc  out  1  registered, one-cycle pulse after a misaligned redirect

Behaviour:
- Reset (async, any cycle, including mid-branch): pc=RESET_PC, branch_taken=0, pc_exc=0, counters=0. Released synchronously on the next clk edge.
- cond_ok per BranchType: BEQ Zero; BNE !Zero; BLEZ Sign|Zero; BGTZ !Sign&!Zero; BLTZ Sign; BGEZ !Sign; 6-7 0.
- PCWriteetc = !stall & (PCWrite | jr_control | (PCWriteCond & cond_ok)). Purely combinational, no latency.
- jr_control forces the source to jr_target regardless of PCSource. Otherwise sources are decoded from PCSource.
- Jump target = {pc[WIDTH-1:28], jump_index, 2'b00}, truncated or zero-extended to WIDTH.
- Misalignment: if PCWriteetc and next[1:0]!=0, the clock edge loads pc=EXC_VECTOR and pc_exc=1 the following cycle. branch_taken=0 on that edge.
- Normal update: on a clock edge with PCWriteetc, pc<=next. branch_taken<=PCWriteCond&cond_ok&!stall&aligned. Otherwise pc holds and both pulses return to 0.
- Simultaneous strobes: priority is jr_control > PCWrite > PCWriteCond. The target comes from the winning source. branch_taken asserts only if PCWriteCond alone caused the write (PCWrite=0, jr_control=0).
- stall=1 overrides all strobes. No write, no pulses, counters hold.
- Wrap-around: pc+4 arithmetic happens in the ALU. At all-ones minus 3 it wraps to 0 naturally, with no exception.

Optional Feature:
PC_PERF_CNT_EN. When defined, adds outputs perf_taken (CNT_W), perf_not_taken (CNT_W) and perf_redirect (CNT_W).
- perf_taken increments per taken conditional branch.
- perf_not_taken increments per PCWriteCond cycle with !cond_ok and !stall.
- perf_redirect increments per jr or misaligned redirect.
- All three saturate at all-ones and are cleared by reset.
When undefined, these ports and registers do not exist, and the remaining behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - BranchType localparams (BR_BEQ..BR_BGEZ).
  - PCSource localparams (PCSRC_ALU, PCSRC_ALUOUT, PCSRC_JUMP, PCSRC_JR).
  - Default EXC_VECTOR.
- One sub-module, branch_cond_eval: combinational cond_ok from BranchType, Zero and Sign, reusable by a later pipelined core.

Test Plan:
- reset=1 mid-operation with pc=0x40 -> pc=0x0000_0000 immediately. Pulses are 0.
- PCWrite=1, PCSource=0, alu_result=0x04 -> pc=0x04 next edge. branch_taken stays 0.
- PCWriteCond=1, BranchType=BNE, Zero=0, alu_out=0x100 -> pc=0x100, branch_taken=1 for one cycle. Repeat with Zero=1 -> pc holds.
- Sweep all six BranchType values × (Zero,Sign) in {00,01,10} -> taken exactly per the cond_ok table. BLEZ with Zero=1 is taken.
- jr_control=1, PCSource=0, jr_target=0x103 -> pc=0x8000_0180, pc_exc=1 for one cycle. With stall=1 instead -> pc unchanged and no pulse.
- PCWrite=1, PCSource=2, pc=0xF000_0010, jump_index=0x0000_040 -> pc=0xF000_0100. With PC_PERF_CNT_EN, perf counters match the tallies from the previous scenarios.
